alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit data, 4-bit op and 4-bit register address.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  upstream instruction present.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 in_op  input  4  ALU opcode.
REQ-007 in_rd, in_rs1, in_rs2  input  4 each  destination and source register indices.
REQ-008 in_use_imm  input  1  when 1, operand B is in_imm instead of reg[rs2].
REQ-009 in_imm  input  32  immediate operand.
REQ-010 wb_en, wb_addr, wb_data  input  1/4/32  result writeback from the ALU consumer.
REQ-011 out_valid  output  1  the issued instruction is held for the ALU.
REQ-012 out_ready  input  1  the downstream stage consumes the instruction.
REQ-013 out_a, out_b  output  32 each  ALU operands.
REQ-014 out_op  output  4  opcode.
REQ-015 out_rd  output  4  destination index.
REQ-016 out_illegal  output  1  opcode is not implemented.
REQ-017 issue_count  output  16  count of accepted instructions.

Function
REQ-018 The register file SHALL hold 16 x 32-bit registers, and r0 SHALL always read as 0.
REQ-019 Writes to r0 SHALL be ignored.
REQ-020 Legal opcodes SHALL be 0 (add), 1 (sub), 8 (and), 9 (or), 10 (xor), 11 (xnor), 12 (shl), 13 (shr) and 14 (sra); all others SHALL set out_illegal=1.
REQ-021 An illegal instruction SHALL still issue normally, but SHALL NOT mark rd busy.
REQ-022 Each register r1..r15 SHALL have a scoreboard busy bit.
REQ-023 A hazard SHALL exist when busy[rs1], busy[rs2] (only if in_use_imm=0) or busy[rd] is set, unless wb_en=1 and wb_addr equals that register in the same cycle; index 0 never causes a hazard.
REQ-024 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !rst, combinationally.
REQ-025 An accept (in_valid && in_ready) SHALL load the output register at the next edge, with 1-cycle latency from accept to out_valid=1.
REQ-026 The output register SHALL capture:
  - out_a = reg[rs1];
  - out_b = in_use_imm ? in_imm : reg[rs2];
  - out_op, out_rd and out_illegal.
REQ-027 Write-to-read bypass: if wb_en=1 and wb_addr equals a source (nonzero), the captured operand SHALL be wb_data.
REQ-028 On an accept, busy[in_rd] SHALL be set (if in_rd != 0 and the op is legal).
REQ-029 A writeback SHALL clear busy[wb_addr].
REQ-030 If a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-031 out_valid SHALL be held with all out_* stable until out_ready=1.
REQ-032 When out_ready=1 and there is no new accept, out_valid SHALL go to 0 at the next edge.
REQ-033 A simultaneous drain and accept SHALL replace the held entry with no bubble.
REQ-034 issue_count SHALL increment by 1 per accept and wrap from 0xFFFF to 0x0000.
REQ-035 A writeback SHALL update the register file at the edge whether or not an accept occurs.

Reset
REQ-036 While rst=1 at an edge, the block SHALL clear:
  - out_valid, out_a, out_b, out_op, out_rd, out_illegal and issue_count to 0;
  - all busy bits to 0;
  - all registers to 0.
REQ-037 A reset asserted while an instruction is held SHALL discard that instruction.
REQ-038 A writeback in a reset cycle SHALL be ignored.
REQ-039 in_ready SHALL be 0 during reset.

Verification
REQ-040 Reset, then writeback r1=5 and r2=3, then issue op=1 rd=3 rs1=1 rs2=2 -> out_valid=1 one cycle after accept, with out_a=5, out_b=3, out_op=1 and out_rd=3.
REQ-041 Issue rd=4; next cycle issue rs1=4 -> in_ready=0 until wb_en=1 wb_addr=4 wb_data=0x1234; in that cycle accept, with out_a=0x1234 (bypass).
REQ-042 Hold out_ready=0 for 3 cycles -> out_* stable and in_ready=0; then out_ready=1 together with in_valid=1 -> new entry loaded back-to-back.
REQ-043 Issue op=5 -> out_illegal=1 and busy[rd] remains clear; a following instruction reading that rd issues without stall.
REQ-044 Issue rs1=0 with in_use_imm=1 and in_imm=0xFFFFFFFF, and writeback to r0 -> out_a=0, out_b=0xFFFFFFFF, r0 still reads 0.
REQ-045 Preload issue_count=0xFFFF via 65535 accepts, then one more accept -> issue_count=0; assert rst with out_valid=1 -> out_valid=0 and all busy bits cleared the next cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Issue stage in front of a single ALU. It holds a 16 x 32-bit register file
// (r0 hard-wired to zero) and a per-register busy scoreboard. It also holds a
// one-entry output register that presents the operands, opcode and
// destination to the ALU.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. valid does not depend on ready. Once
// out_valid is 1, it and all out_* stay stable until out_ready is 1.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  upstream instruction handshake
//   in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm
//                        instruction fields
//   wb_en, wb_addr, wb_data
//                        result writeback from the ALU consumer
//   out_valid / out_ready
//                        downstream handshake
//   out_a, out_b, out_op, out_rd, out_illegal
//                        issued instruction
//   issue_count          wrapping 16-bit count of accepted instructions
// ---------------------------------------------------------------------------
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic        in_use_imm,
  input  logic [31:0] in_imm,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_op,
  output logic [3:0]  out_rd,
  output logic        out_illegal,
  output logic [15:0] issue_count
);

  // State
  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];
  logic [15:0] busy_q, busy_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_a_q, out_a_d;
  logic [31:0] out_b_q, out_b_d;
  logic [3:0]  out_op_q, out_op_d;
  logic [3:0]  out_rd_q, out_rd_d;
  logic        out_illegal_q, out_illegal_d;
  logic [15:0] issue_count_q, issue_count_d;

  // Combinational helpers
  logic        op_illegal;
  logic        haz_rs1, haz_rs2, haz_rd, hazard;
  logic        accept;
  logic [31:0] rs1_val, rs2_val;

  // A busy register blocks issue unless its result is being written back in
  // this very cycle; the bypass below then supplies the fresh value.
  function automatic logic busy_hit(input logic [15:0] busy, input logic [3:0] idx,
                                    input logic wen, input logic [3:0] waddr);
    busy_hit = (idx != 4'd0) && busy[idx] && !(wen && (waddr == idx));
  endfunction

  always_comb begin
    op_illegal = 1'b1;
    case (in_op)
      4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14: op_illegal = 1'b0;
      default:                                                   op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    haz_rs1 = busy_hit(busy_q, in_rs1, wb_en, wb_addr);
    haz_rs2 = !in_use_imm && busy_hit(busy_q, in_rs2, wb_en, wb_addr);
    haz_rd  = busy_hit(busy_q, in_rd, wb_en, wb_addr);
    hazard  = haz_rs1 || haz_rs2 || haz_rd;
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !rst;
  assign accept   = in_valid && in_ready;

  // Operand read with write-to-read bypass; r0 always reads zero.
  always_comb begin
    rs1_val = 32'd0;
    if (in_rs1 != 4'd0) begin
      if (wb_en && (wb_addr == in_rs1)) rs1_val = wb_data;
      else                               rs1_val = regs_q[in_rs1];
    end
    rs2_val = 32'd0;
    if (in_rs2 != 4'd0) begin
      if (wb_en && (wb_addr == in_rs2)) rs2_val = wb_data;
      else                               rs2_val = regs_q[in_rs2];
    end
  end

  // Register file: writeback lands regardless of issue activity.
  always_comb begin
    for (int i = 0; i < 16; i++) regs_d[i] = regs_q[i];
    if (wb_en && (wb_addr != 4'd0)) regs_d[wb_addr] = wb_data;
  end

  // Scoreboard: clear on writeback first so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (accept && (in_rd != 4'd0) && !op_illegal) busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Output register: load on accept (covers drain+accept with no bubble),
  // otherwise drop valid once consumed; payload is left untouched.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_op_d      = out_op_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    issue_count_d = issue_count_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_a_d       = rs1_val;
      out_b_d       = in_use_imm ? in_imm : rs2_val;
      out_op_d      = in_op;
      out_rd_d      = in_rd;
      out_illegal_d = op_illegal;
      issue_count_d = issue_count_q + 16'd1;
    end else if (out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 32'd0;
      busy_q        <= 16'd0;
      out_valid_q   <= 1'b0;
      out_a_q       <= 32'd0;
      out_b_q       <= 32'd0;
      out_op_q      <= 4'd0;
      out_rd_q      <= 4'd0;
      out_illegal_q <= 1'b0;
      issue_count_q <= 16'd0;
    end else begin
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_op_q      <= out_op_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_op      = out_op_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage: directed scenarios for alu_issue_stage with
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op, in_rd, in_rs1, in_rs2;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_op, out_rd;
  logic        out_illegal;
  logic [15:0] issue_count;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
    .out_illegal(out_illegal), .issue_count(issue_count)
  );

  // Driver tasks: all inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [3:0] op, input logic [3:0] rd,
                             input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic use_imm, input logic [31:0] imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_use_imm = use_imm;
    in_imm     = imm;
  endtask

  task automatic drive_wb(input logic en, input logic [3:0] addr, input logic [31:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive_wb(1'b0, 4'd0, 32'd0);
    tick();
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    drive_instr(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0);
    in_valid = 1'b0;
    drive_wb(1'b0, 4'd0, 32'd0);
    tick(); tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_vec++; if (issue_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %h exp 0000", issue_count); end
    n_vec++; if (out_a !== 32'd0 || out_b !== 32'd0) begin n_err++; $display("FAIL reset_operands: got %h/%h exp 0/0", out_a, out_b); end
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    drive_wb(1'b1, 4'd1, 32'd5); tick();
    drive_wb(1'b1, 4'd2, 32'd3); tick();
    drive_wb(1'b0, 4'd0, 32'd0);
    drive_instr(4'd1, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b exp 1", out_valid); end
    n_vec++; if (out_a !== 32'd5) begin n_err++; $display("FAIL basic_a: got %h exp %h", out_a, 32'd5); end
    n_vec++; if (out_b !== 32'd3) begin n_err++; $display("FAIL basic_b: got %h exp %h", out_b, 32'd3); end
    n_vec++; if (out_op !== 4'd1 || out_rd !== 4'd3 || out_illegal !== 1'b0) begin
      n_err++; $display("FAIL basic_fields: got op=%0d rd=%0d ill=%b exp op=1 rd=3 ill=0", out_op, out_rd, out_illegal); end
    n_vec++; if (issue_count !== 16'd1) begin n_err++; $display("FAIL basic_count: got %h exp 0001", issue_count); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b exp 0", out_valid); end
    // r3 is busy: reading it must stall until its writeback.
    drive_instr(4'd0, 4'd0, 4'd3, 4'd0, 1'b0, 32'd0);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy_rd3: got %b exp 0", in_ready); end
    in_valid = 1'b0;
    drive_wb(1'b1, 4'd3, 32'd2); tick();
    idle();
  endtask

  task automatic test_bypass();
    drive_instr(4'd0, 4'd4, 4'd1, 4'd2, 1'b0, 32'd0);
    tick();
    drive_instr(4'd0, 4'd5, 4'd4, 4'd0, 1'b0, 32'd0);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bypass_stall0: got %b exp 0", in_ready); end
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bypass_stall1: got %b exp 0", in_ready); end
    drive_wb(1'b1, 4'd4, 32'h1234);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    drive_wb(1'b0, 4'd0, 32'd0);
    n_vec++; if (out_a !== 32'h1234) begin n_err++; $display("FAIL bypass_a: got %h exp %h", out_a, 32'h1234); end
    n_vec++; if (out_rd !== 4'd5 || out_b !== 32'd0) begin n_err++; $display("FAIL bypass_fields: got rd=%0d b=%h exp rd=5 b=0", out_rd, out_b); end
    n_vec++; if (issue_count !== 16'd3) begin n_err++; $display("FAIL bypass_count: got %h exp 0003", issue_count); end
    drive_wb(1'b1, 4'd5, 32'h55); tick();
    idle();
  endtask

  task automatic test_hold_back_to_back();
    out_ready = 1'b0;
    // r4 now holds 0x1234 from the writeback, r1=5, r2=3.
    drive_instr(4'd8, 4'd6, 4'd1, 4'd4, 1'b0, 32'd0);
    tick();
    drive_instr(4'd9, 4'd7, 4'd2, 4'd1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b exp 0", i, in_ready); end
      n_vec++; if (out_valid !== 1'b1 || out_a !== 32'd5 || out_b !== 32'h1234 || out_op !== 4'd8 || out_rd !== 4'd6) begin
        n_err++; $display("FAIL hold_stable[%0d]: got v=%b a=%h b=%h op=%0d rd=%0d exp v=1 a=5 b=1234 op=8 rd=6",
                          i, out_valid, out_a, out_b, out_op, out_rd); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_a !== 32'd3 || out_b !== 32'd5 || out_op !== 4'd9 || out_rd !== 4'd7) begin
      n_err++; $display("FAIL b2b_entry: got v=%b a=%h b=%h op=%0d rd=%0d exp v=1 a=3 b=5 op=9 rd=7",
                        out_valid, out_a, out_b, out_op, out_rd); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b exp 0", out_valid); end
    drive_wb(1'b1, 4'd6, 32'd0); tick();
    drive_wb(1'b1, 4'd7, 32'd0); tick();
    idle();
  endtask

  task automatic test_illegal();
    logic exp_ill;
    drive_instr(4'd5, 4'd8, 4'd1, 4'd2, 1'b0, 32'd0);
    tick();
    drive_instr(4'd0, 4'd9, 4'd8, 4'd8, 1'b0, 32'd0);
    n_vec++; if (out_illegal !== 1'b1 || out_op !== 4'd5) begin
      n_err++; $display("FAIL illegal_flag: got ill=%b op=%0d exp ill=1 op=5", out_illegal, out_op); end
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_no_stall: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_illegal !== 1'b0 || out_a !== 32'd0 || out_rd !== 4'd9) begin
      n_err++; $display("FAIL illegal_follow: got ill=%b a=%h rd=%0d exp ill=0 a=0 rd=9", out_illegal, out_a, out_rd); end
    drive_wb(1'b1, 4'd9, 32'd0); tick();
    drive_wb(1'b0, 4'd0, 32'd0);
    // Sweep every opcode with rd=0 (no scoreboard side effects).
    for (int op = 0; op < 16; op++) begin
      exp_ill = !(op == 0 || op == 1 || (op >= 8 && op <= 14));
      drive_instr(op[3:0], 4'd0, 4'd0, 4'd0, 1'b0, 32'd0);
      tick();
      n_vec++; if (out_illegal !== exp_ill || out_op !== op[3:0]) begin
        n_err++; $display("FAIL opcode_sweep[%0d]: got ill=%b op=%0d exp ill=%b", op, out_illegal, out_op, exp_ill); end
    end
    idle();
  endtask

  task automatic test_r0_and_imm();
    drive_instr(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFF);
    drive_wb(1'b1, 4'd0, 32'hDEAD_BEEF);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready: got %b exp 1", in_ready); end
    tick();
    drive_wb(1'b0, 4'd0, 32'd0);
    n_vec++; if (out_a !== 32'd0 || out_b !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL r0_imm: got a=%h b=%h exp a=0 b=ffffffff", out_a, out_b); end
    drive_instr(4'd10, 4'd0, 4'd0, 4'd0, 1'b0, 32'h1111_1111);
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_a !== 32'd0 || out_b !== 32'd0) begin
      n_err++; $display("FAIL r0_read: got a=%h b=%h exp 0/0", out_a, out_b); end
    idle();
  endtask

  task automatic test_set_wins();
    // Issue rd=10 while r10 is being written back: busy must end up set.
    drive_instr(4'd0, 4'd10, 4'd0, 4'd0, 1'b0, 32'd0);
    drive_wb(1'b1, 4'd10, 32'h77);
    tick();
    drive_wb(1'b0, 4'd0, 32'd0);
    drive_instr(4'd0, 4'd0, 4'd10, 4'd0, 1'b0, 32'd0);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL set_wins: got %b exp 0", in_ready); end
    // rs2 hazard is ignored when the immediate is used.
    drive_instr(4'd0, 4'd0, 4'd0, 4'd10, 1'b1, 32'd9);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL imm_masks_rs2: got %b exp 1", in_ready); end
    in_valid = 1'b0;
    drive_wb(1'b1, 4'd10, 32'h88); tick();
    idle();
  endtask

  task automatic test_count_wrap_and_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    drive_instr(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0);
    repeat (65535) tick();
    n_vec++; if (issue_count !== 16'hFFFF) begin n_err++; $display("FAIL count_ffff: got %h exp ffff", issue_count); end
    tick();
    n_vec++; if (issue_count !== 16'h0000) begin n_err++; $display("FAIL count_wrap: got %h exp 0000", issue_count); end
    // Hold an entry with r11 busy, then reset with a writeback pending.
    drive_instr(4'd0, 4'd11, 4'd1, 4'd0, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_held: got %b exp 1", out_valid); end
    rst = 1'b1;
    drive_wb(1'b1, 4'd12, 32'h77);
    tick();
    rst = 1'b0;
    drive_wb(1'b0, 4'd0, 32'd0);
    n_vec++; if (out_valid !== 1'b0 || issue_count !== 16'd0) begin
      n_err++; $display("FAIL reset_discard: got v=%b cnt=%h exp v=0 cnt=0", out_valid, issue_count); end
    out_ready = 1'b1;
    drive_instr(4'd0, 4'd0, 4'd11, 4'd12, 1'b0, 32'd0);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_busy_clear: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_a !== 32'd0 || out_b !== 32'd0) begin
      n_err++; $display("FAIL reset_regs_clear: got a=%h b=%h exp 0/0", out_a, out_b); end
    drive_instr(4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_a !== 32'd0) begin n_err++; $display("FAIL reset_r1_clear: got %h exp 0", out_a); end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_hold_back_to_back();
    test_illegal();
    test_r0_and_imm();
    test_set_wins();
    test_count_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
